// File: rtl/ercm_pkg.sv
// Shared definitions for the error-recovery approximate multiplier.
//   clog2      : ceiling log2 for parameter sizing
//   ERCM_LAT   : accepted-to-valid latency of ercm_pipe_mult, in cycles
//   ercm_model : bit-accurate reference of the approximate product
//                (a, b zero-extended; width = operand width, 4..32)
package ercm_pkg;

  localparam int unsigned ERCM_LAT = 3;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Walks the OR tree level by level, in place: node k of the next level
  // only overwrites slots already consumed (k <= 2k).
  function automatic logic [63:0] ercm_model(input logic [31:0]   a,
                                             input logic [31:0]   b,
                                             input logic [63:0]   mask,
                                             input int unsigned   width);
    logic [63:0]  n [32];
    logic [63:0]  lim;
    logic [63:0]  bm;
    logic [63:0]  rec;
    int unsigned  cnt;
    lim = (width >= 32) ? '1 : ((64'd1 << (2 * width)) - 64'd1);
    bm  = {32'b0, b} & ((64'd1 << width) - 64'd1);
    rec = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      n[i] = (i < width && a[i]) ? ((bm << i) & lim) : '0;
    end
    cnt = width;
    for (int unsigned l = 0; l < 5; l++) begin
      if (cnt > 1) begin
        for (int unsigned k = 0; k < 16; k++) begin
          if (k < cnt / 2) begin
            rec  = rec + ((n[2*k] & n[2*k+1]) & mask);
            n[k] = n[2*k] | n[2*k+1];
          end
        end
        cnt = cnt / 2;
      end
    end
    return (n[0] + rec) & lim;
  endfunction

endpackage

// File: rtl/ercm_or_tree.sv
// Combinational partial-product OR tree.
//   a, b    : unsigned operands (WIDTH bits)
//   root_s  : OR-compressed sum of all partial products (2*WIDTH bits)
//   carry   : lost carry (AND term) of every tree node, one vector per node.
//             Node index = WIDTH - (WIDTH >> l) + k for node k produced from
//             level l; level 0 (the partial products) has no carries.
module ercm_or_tree
  import ercm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  output logic [2*WIDTH-1:0]               root_s,
  output logic [WIDTH-2:0][2*WIDTH-1:0]    carry
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned L  = clog2(WIDTH);

  // Heap of all tree nodes: leaves at 0..WIDTH-1, level l starts at
  // 2*WIDTH - (2*WIDTH >> l), root in the last slot.
  logic [2*WIDTH-2:0][PW-1:0] node;

  // Carries stay per node: carries of one level can share columns, and the
  // masked sum must be taken per node to make an all-ones mask exact.
  always_comb begin
    node  = '0;
    carry = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      node[i] = a[i] ? ({{WIDTH{1'b0}}, b} << i) : '0;
    end
    for (int unsigned l = 0; l < L; l++) begin
      for (int unsigned k = 0; k < (WIDTH >> (l + 1)); k++) begin
        node[PW - (PW >> (l + 1)) + k] =
          node[PW - (PW >> l) + 2*k] | node[PW - (PW >> l) + 2*k + 1];
        carry[WIDTH - (WIDTH >> l) + k] =
          node[PW - (PW >> l) + 2*k] & node[PW - (PW >> l) + 2*k + 1];
      end
    end
    root_s = node[PW-2];
  end

endmodule

// File: rtl/ercm_pipe_mult.sv
// Pipelined error-recovery approximate multiplier, unsigned WIDTH x WIDTH.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand beat handshake (in_ready = pipeline advance)
//   dat_in_a, dat_in_b  : operands
//   mask                : per-output-column carry recovery enable
//   tag_in / tag_o      : sideband tag travelling with each beat
//   out_valid/out_ready : result handshake
//   dat_o               : approximate product, 3 cycles after acceptance
// Global-stall pipeline: every stage advances together when the output
// register is empty or being consumed; bubbles are kept.
module ercm_pipe_mult
  import ercm_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     dat_in_a,
  input  logic [WIDTH-1:0]     dat_in_b,
  input  logic [2*WIDTH-1:0]   mask,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   dat_o,
  output logic [TAG_W-1:0]     tag_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned L  = clog2(WIDTH);

  logic                         en;
  logic [PW-1:0]                root_s;
  logic [WIDTH-2:0][PW-1:0]     carry;

  // Stage 1: tree outputs, mask, tag
  logic                         v1_d, v1_q;
  logic [PW-1:0]                root1_d, root1_q;
  logic [WIDTH-2:0][PW-1:0]     carry1_d, carry1_q;
  logic [PW-1:0]                mask1_d, mask1_q;
  logic [TAG_W-1:0]             tag1_d, tag1_q;
  // Stage 2: per-level masked carry sums
  logic                         v2_d, v2_q;
  logic [PW-1:0]                root2_d, root2_q;
  logic [L-1:0][PW-1:0]         rec2_d, rec2_q;
  logic [TAG_W-1:0]             tag2_d, tag2_q;
  // Stage 3: final sum
  logic                         out_valid_d, out_valid_q;
  logic [PW-1:0]                dat_d, dat_q;
  logic [TAG_W-1:0]             tag_d, tag_q;

  ercm_or_tree #(.WIDTH(WIDTH)) u_tree (
    .a      (dat_in_a),
    .b      (dat_in_b),
    .root_s (root_s),
    .carry  (carry)
  );

  always_comb begin
    en          = ~out_valid_q | out_ready;

    v1_d        = in_valid;
    root1_d     = root_s;
    carry1_d    = carry;
    mask1_d     = mask;
    tag1_d      = tag_in;

    v2_d        = v1_q;
    root2_d     = root1_q;
    tag2_d      = tag1_q;
    rec2_d      = '0;
    for (int unsigned l = 0; l < L; l++) begin
      for (int unsigned k = 0; k < (WIDTH >> (l + 1)); k++) begin
        rec2_d[l] = rec2_d[l] + (carry1_q[WIDTH - (WIDTH >> l) + k] & mask1_q);
      end
    end

    out_valid_d = v2_q;
    tag_d       = tag2_q;
    dat_d       = root2_q;
    for (int unsigned l = 0; l < L; l++) begin
      dat_d = dat_d + rec2_q[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      dat_q       <= '0;
      tag_q       <= '0;
    end else if (en) begin
      v1_q        <= v1_d;
      root1_q     <= root1_d;
      carry1_q    <= carry1_d;
      mask1_q     <= mask1_d;
      tag1_q      <= tag1_d;
      v2_q        <= v2_d;
      root2_q     <= root2_d;
      rec2_q      <= rec2_d;
      tag2_q      <= tag2_d;
      out_valid_q <= out_valid_d;
      dat_q       <= dat_d;
      tag_q       <= tag_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign dat_o     = dat_q;
  assign tag_o     = tag_q;

endmodule

// File: tb/tb_ercm_pipe_mult.sv
module tb_ercm_pipe_mult;
  import ercm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready_hi = 1'b1;

  // WIDTH = 8 instance (full handshake exercised)
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] mask8 = '0, dat8;
  logic [3:0]  tag_in = '0, tag_o;

  // WIDTH = 4 instance
  logic        iv4 = 1'b0, ir4, ov4;
  logic [3:0]  a4 = '0, b4 = '0, ti4 = '0, to4;
  logic [7:0]  m4 = '0, d4;

  // WIDTH = 16 instance
  logic        iv16 = 1'b0, ir16, ov16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] m16 = '0, d16;
  logic [3:0]  ti16 = '0, to16;

  int vectors = 0, miscompares = 0, results = 0;
  logic last_in_ready;

  typedef struct packed { logic [15:0] d; logic [3:0] t; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ercm_pipe_mult #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dat_in_a(a8), .dat_in_b(b8), .mask(mask8), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .dat_o(dat8), .tag_o(tag_o));

  ercm_pipe_mult #(.WIDTH(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .dat_in_a(a4), .dat_in_b(b4), .mask(m4), .tag_in(ti4),
    .out_valid(ov4), .out_ready(ready_hi), .dat_o(d4), .tag_o(to4));

  ercm_pipe_mult #(.WIDTH(16), .TAG_W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .dat_in_a(a16), .dat_in_b(b16), .mask(m16), .tag_in(ti16),
    .out_valid(ov16), .out_ready(ready_hi), .dat_o(d16), .tag_o(to16));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One cycle on the WIDTH=8 DUT, entered and left 1 time unit after a clock
  // edge. Results are checked against the scoreboard in acceptance order.
  task automatic cyc(input logic v, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] m, input logic [3:0] t,
                     input logic [15:0] exp, input logic rdy);
    in_valid = v; a8 = a; b8 = b; mask8 = m; tag_in = t; out_ready = rdy;
    #1;
    last_in_ready = in_ready;
    if (out_valid) begin
      if (sb.size() == 0) check("stray_out_valid", out_valid, 0);
      else begin
        check("dat_o", dat8, sb[0].d);
        check("tag_o", tag_o, sb[0].t);
        if (rdy) begin
          void'(sb.pop_front());
          results++;
        end
      end
    end
    if (v && in_ready) sb.push_back('{d: exp, t: t});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 8'd0, 16'd0, 4'd0, 16'd0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) cyc(1'b0, 8'd0, 8'd0, 16'd0, 4'd0, 16'd0, 1'b1);
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic one4(input string nm, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] m, input logic [7:0] exp);
    iv4 = 1'b1; a4 = a; b4 = b; m4 = m; ti4 = a ^ b;
    check({nm, "_in_ready"}, ir4, 1);
    @(posedge clk); #1;
    iv4 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check({nm, "_valid"}, ov4, 1);
    check(nm, d4, exp);
    check({nm, "_tag"}, to4, a ^ b);
    @(posedge clk); #1;
  endtask

  task automatic one16(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] m, input logic [31:0] exp);
    iv16 = 1'b1; a16 = a; b16 = b; m16 = m; ti16 = a[3:0] ^ b[3:0];
    check({nm, "_in_ready"}, ir16, 1);
    @(posedge clk); #1;
    iv16 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check({nm, "_valid"}, ov16, 1);
    check(nm, d16, exp);
    check({nm, "_tag"}, to16, a[3:0] ^ b[3:0]);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] rm, hold_d;
    logic [3:0]  hold_t;
    logic [63:0] mdl;
    logic [31:0] r32a, r32b, r32m;
    logic [3:0]  r4a, r4b;
    logic [7:0]  r4m;
    logic        rv, rr;
    int          r0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_dat_o", dat8, 0);
    check("rst_tag_o", tag_o, 0);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);

    // Directed W=8 vectors, back to back
    cyc(1'b1, 8'd3,   8'd3,   16'h0000, 4'd1, 16'd7,     1'b1);
    cyc(1'b1, 8'd3,   8'd3,   16'h0002, 4'd2, 16'd9,     1'b1);
    cyc(1'b1, 8'd3,   8'd3,   16'hFFFF, 4'd3, 16'd9,     1'b1);
    cyc(1'b1, 8'h0F,  8'h03,  16'h0000, 4'd4, 16'd31,    1'b1);
    cyc(1'b1, 8'h0F,  8'h03,  16'hFFFF, 4'd5, 16'd45,    1'b1);
    cyc(1'b1, 8'h0F,  8'h03,  16'h0004, 4'd6, 16'd35,    1'b1);
    cyc(1'b1, 8'hFF,  8'hFF,  16'hFFFF, 4'd7, 16'd65025, 1'b1);
    cyc(1'b1, 8'h00,  8'hAB,  16'hFFFF, 4'd8, 16'd0,     1'b1);
    cyc(1'b1, 8'h5A,  8'h00,  16'h1234, 4'd9, 16'd0,     1'b1);
    cyc(1'b1, 8'd3,   8'd3,   16'hFFF2, 4'd10, 16'd9,    1'b1);
    cyc(1'b1, 8'd3,   8'd3,   16'hFFFC, 4'd11, 16'd7,    1'b1);
    drain();

    // Full throughput: 100 beats, first result ERCM_LAT cycles after first accept
    r0 = results;
    for (int k = 0; k < 104; k++) begin
      check("t4_out_valid", out_valid, (k >= int'(ERCM_LAT) && k < 100 + int'(ERCM_LAT)));
      ra = k[7:0];
      rb = ra ^ 8'h5A;
      if (k < 100) cyc(1'b1, ra, rb, 16'hFFFF, k[3:0], {8'b0, ra} * {8'b0, rb}, 1'b1);
      else         cyc(1'b0, 8'd0, 8'd0, 16'd0, 4'd0, 16'd0, 1'b1);
    end
    check("t4_results", results - r0, 100);
    drain();

    // Stall with a full pipeline
    r0 = results;
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 8'(10 + i), 8'(20 + i), 16'hFFFF, 4'(8 + i), 16'((10 + i) * (20 + i)), 1'b1);
    check("t5_full", out_valid, 1);
    hold_d = dat8;
    hold_t = tag_o;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'd13, 8'd23, 16'hFFFF, 4'd11, 16'd299, 1'b0);
      check("t5_in_ready", last_in_ready, 0);
      check("t5_dat_hold", dat8, hold_d);
      check("t5_tag_hold", tag_o, hold_t);
    end
    for (int i = 3; i < 6; i++)
      cyc(1'b1, 8'(10 + i), 8'(20 + i), 16'hFFFF, 4'(8 + i), 16'((10 + i) * (20 + i)), 1'b1);
    drain();
    check("t5_results", results - r0, 6);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 8'(40 + i), 8'd7, 16'hFFFF, 4'(i), 16'((40 + i) * 7), 1'b1);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_dat_o", dat8, 0);
    check("t6_tag_o", tag_o, 0);
    rst = 1'b0;
    sb.delete();
    check("t6_in_ready", in_ready, 1);
    idle(6);

    // Random, mask all-ones against the true product
    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      cyc(1'b1, ra, rb, 16'hFFFF, 4'(i), {8'b0, ra} * {8'b0, rb}, 1'b1);
    end
    drain();

    // Random mask, valid and ready against the reference model
    for (int i = 0; i < 1500; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rm = 16'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      mdl = ercm_model({24'b0, ra}, {24'b0, rb}, {48'b0, rm}, 8);
      cyc(rv, ra, rb, rm, 4'(i), mdl[15:0], rr);
    end
    drain();

    // WIDTH = 4
    one4("w4_3x3_m0",   4'd3,  4'd3,  8'h00, 8'd7);
    one4("w4_3x3_m2",   4'd3,  4'd3,  8'h02, 8'd9);
    one4("w4_3x3_m1s",  4'd3,  4'd3,  8'hFF, 8'd9);
    one4("w4_Fx3_m0",   4'hF,  4'h3,  8'h00, 8'd31);
    one4("w4_Fx3_m1s",  4'hF,  4'h3,  8'hFF, 8'd45);
    one4("w4_Fx3_m4",   4'hF,  4'h3,  8'h04, 8'd35);
    one4("w4_FxF_m1s",  4'hF,  4'hF,  8'hFF, 8'd225);
    one4("w4_0xB",      4'h0,  4'hB,  8'hFF, 8'd0);
    for (int i = 0; i < 20; i++) begin
      r4a = 4'($urandom); r4b = 4'($urandom); r4m = 8'($urandom);
      one4("w4_rand_exact", r4a, r4b, 8'hFF, {4'b0, r4a} * {4'b0, r4b});
      mdl = ercm_model({28'b0, r4a}, {28'b0, r4b}, {56'b0, r4m}, 4);
      one4("w4_rand_model", r4a, r4b, r4m, mdl[7:0]);
    end

    // WIDTH = 16
    one16("w16_3x3_m0",  16'd3,    16'd3,    32'h0000_0000, 32'd7);
    one16("w16_3x3_m2",  16'd3,    16'd3,    32'h0000_0002, 32'd9);
    one16("w16_3x3_m1s", 16'd3,    16'd3,    32'hFFFF_FFFF, 32'd9);
    one16("w16_Fx3_m0",  16'h000F, 16'h0003, 32'h0000_0000, 32'd31);
    one16("w16_Fx3_m1s", 16'h000F, 16'h0003, 32'hFFFF_FFFF, 32'd45);
    one16("w16_Fx3_m4",  16'h000F, 16'h0003, 32'h0000_0004, 32'd35);
    one16("w16_max",     16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFE_0001);
    one16("w16_zero",    16'h1234, 16'h0000, 32'hDEAD_BEEF, 32'd0);
    for (int i = 0; i < 20; i++) begin
      r32a = {16'b0, 16'($urandom)}; r32b = {16'b0, 16'($urandom)}; r32m = $urandom;
      one16("w16_rand_exact", r32a[15:0], r32b[15:0], 32'hFFFF_FFFF, r32a * r32b);
      mdl = ercm_model(r32a, r32b, {32'b0, r32m}, 16);
      one16("w16_rand_model", r32a[15:0], r32b[15:0], r32m, mdl[31:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
